xm23_alu_core: RTL and testbench

- Registered arithmetic/logic unit for the XM23 CPU datapath.
- Combines destination operand d_bus with source operand s_bus according to alu_op.
- Produces the 16-bit result and an updated copy of the PSW, with flags C, Z, N and V.
- The control unit selects the operation and the flag-update enable; the top level samples the outputs on the falling edge of Clock.

---
 rtl/xm23_alu_core.sv | 196 +++++++++++++++++++
 tb/tb_xm23_alu_core.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/xm23_alu_core.sv
// XM23 registered ALU core.
// Combines the destination operand (d_bus) with the source operand (s_bus) per alu_op and
// registers both the 16-bit result and an updated PSW. Latency is one cycle.
// Ports:
//   Clock, Reset       - clock (rising edge), async active-high reset
//   d_bus, s_bus       - destination / source operands
//   alu_op             - [5] byte mode, [4:0] opcode
//   psw_out            - current PSW (C=bit0, Z=bit1, N=bit2, V=bit4)
//   psw_update         - 1: write computed flags, 0: pass psw_out through
//   alu_out            - registered result
//   alu_psw_out        - registered PSW after the operation
module xm23_alu_core #(
  parameter logic [15:0] PSW_RESET = 16'h60E0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] d_bus,
  input  logic [15:0] s_bus,
  input  logic [5:0]  alu_op,
  input  logic [15:0] psw_out,
  input  logic        psw_update,
  output logic [15:0] alu_out,
  output logic [15:0] alu_psw_out
);

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpAddc = 5'd1;
  localparam logic [4:0] OpSub  = 5'd2;
  localparam logic [4:0] OpSubc = 5'd3;
  localparam logic [4:0] OpDadd = 5'd4;
  localparam logic [4:0] OpCmp  = 5'd5;
  localparam logic [4:0] OpXor  = 5'd6;
  localparam logic [4:0] OpAnd  = 5'd7;
  localparam logic [4:0] OpOr   = 5'd8;
  localparam logic [4:0] OpBit  = 5'd9;
  localparam logic [4:0] OpBic  = 5'd10;
  localparam logic [4:0] OpBis  = 5'd11;
  localparam logic [4:0] OpMov  = 5'd12;
  localparam logic [4:0] OpSra  = 5'd14;
  localparam logic [4:0] OpRrc  = 5'd15;
  localparam logic [4:0] OpSwpb = 5'd16;
  localparam logic [4:0] OpSxt  = 5'd17;

  logic [4:0]  opcode;
  logic        byte_mode;
  logic        c_in;

  assign opcode    = alu_op[4:0];
  // Opcodes 16 and above are word-only, so byte mode is ignored there.
  assign byte_mode = alu_op[5] & ~opcode[4];
  assign c_in      = psw_out[0];

  // Shared adder for ADD/ADDC/SUB/SUBC/CMP; subtract forms add the complemented source.
  logic        sub_op;
  logic        add_cin;
  logic [15:0] add_b;
  logic [16:0] sum_w;
  logic [8:0]  sum_b;
  logic        arith_c;
  logic        arith_v;
  logic        msb_a;
  logic        msb_b;
  logic        msb_r;

  always_comb begin
    sub_op = (opcode == OpSub) || (opcode == OpSubc) || (opcode == OpCmp);
    add_b  = sub_op ? ~s_bus : s_bus;
    case (opcode)
      OpAddc, OpSubc: add_cin = c_in;
      OpSub, OpCmp:   add_cin = 1'b1;
      default:        add_cin = 1'b0;
    endcase
    sum_w   = {1'b0, d_bus} + {1'b0, add_b} + {16'h0000, add_cin};
    sum_b   = {1'b0, d_bus[7:0]} + {1'b0, add_b[7:0]} + {8'h00, add_cin};
    arith_c = byte_mode ? sum_b[8] : sum_w[16];
    msb_a   = byte_mode ? d_bus[7] : d_bus[15];
    msb_b   = byte_mode ? add_b[7] : add_b[15];
    msb_r   = byte_mode ? sum_b[7] : sum_w[15];
    arith_v = (msb_a == msb_b) && (msb_r != msb_a);
  end

  // Decimal adder: four ripple digits; byte mode takes the carry out of digit 1.
  logic [15:0] bcd_sum;
  logic        bcd_carry_b;
  logic        bcd_carry_w;

  always_comb begin
    logic [4:0] digit;
    logic       dc;
    bcd_sum     = 16'h0000;
    bcd_carry_b = 1'b0;
    dc          = c_in;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, d_bus[4*i +: 4]} + {1'b0, s_bus[4*i +: 4]} + {4'b0000, dc};
      if (digit > 5'd9) begin
        digit = digit - 5'd10;
        dc    = 1'b1;
      end else begin
        dc    = 1'b0;
      end
      bcd_sum[4*i +: 4] = digit[3:0];
      if (i == 1) bcd_carry_b = dc;
    end
    bcd_carry_w = dc;
  end

  // Operation select. val carries the flag-source value; for CMP/BIT it is not written back.
  logic [15:0] val;
  logic        keep_d;
  logic        upd_zn;
  logic        upd_c;
  logic        upd_v;
  logic        c_new;
  logic        v_new;
  logic        z_new;
  logic        n_new;
  logic [15:0] alu_out_d;
  logic [15:0] psw_d;

  always_comb begin
    val    = d_bus;
    keep_d = 1'b0;
    upd_zn = 1'b0;
    upd_c  = 1'b0;
    upd_v  = 1'b0;
    c_new  = c_in;
    v_new  = psw_out[4];
    case (opcode)
      OpAdd, OpAddc, OpSub, OpSubc, OpCmp: begin
        val    = sum_w[15:0];
        c_new  = arith_c;
        v_new  = arith_v;
        upd_zn = 1'b1;
        upd_c  = 1'b1;
        upd_v  = 1'b1;
        keep_d = (opcode == OpCmp);
      end
      OpDadd: begin
        val    = bcd_sum;
        c_new  = byte_mode ? bcd_carry_b : bcd_carry_w;
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
      OpXor: begin val = d_bus ^ s_bus;  upd_zn = 1'b1; end
      OpAnd: begin val = d_bus & s_bus;  upd_zn = 1'b1; end
      OpOr:  begin val = d_bus | s_bus;  upd_zn = 1'b1; end
      OpBit: begin val = d_bus & s_bus;  upd_zn = 1'b1; keep_d = 1'b1; end
      OpBic: begin val = d_bus & ~s_bus; upd_zn = 1'b1; end
      OpBis: begin val = d_bus | s_bus;  upd_zn = 1'b1; end
      OpMov: val = s_bus;
      OpSra: begin
        val    = byte_mode ? {8'h00, d_bus[7], d_bus[7:1]} : {d_bus[15], d_bus[15:1]};
        c_new  = d_bus[0];
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
      OpRrc: begin
        val    = byte_mode ? {8'h00, c_in, d_bus[7:1]} : {c_in, d_bus[15:1]};
        c_new  = d_bus[0];
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
      OpSwpb: begin val = {d_bus[7:0], d_bus[15:8]};    upd_zn = 1'b1; end
      OpSxt:  begin val = {{8{d_bus[7]}}, d_bus[7:0]}; upd_zn = 1'b1; end
      default: keep_d = 1'b1;
    endcase

    z_new = byte_mode ? (val[7:0] == 8'h00) : (val == 16'h0000);
    n_new = byte_mode ? val[7] : val[15];

    if (keep_d)         alu_out_d = d_bus;
    else if (byte_mode) alu_out_d = {d_bus[15:8], val[7:0]};
    else                alu_out_d = val;

    psw_d = psw_out;
    if (psw_update) begin
      if (upd_c) psw_d[0] = c_new;
      if (upd_zn) begin
        psw_d[1] = z_new;
        psw_d[2] = n_new;
      end
      if (upd_v) psw_d[4] = v_new;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      alu_out     <= 16'h0000;
      alu_psw_out <= PSW_RESET;
    end else begin
      alu_out     <= alu_out_d;
      alu_psw_out <= psw_d;
    end
  end

endmodule

// File: tb/tb_xm23_alu_core.sv
// Scoreboard bench for xm23_alu_core: a driver pushes expected results at issue time and a
// monitor pops and compares one entry after each rising edge.
module tb_xm23_alu_core;

  logic        Clock;
  logic        Reset;
  logic [15:0] d_bus;
  logic [15:0] s_bus;
  logic [5:0]  alu_op;
  logic [15:0] psw_out;
  logic        psw_update;
  logic [15:0] alu_out;
  logic [15:0] alu_psw_out;

  xm23_alu_core #(.PSW_RESET(16'h60E0)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .d_bus      (d_bus),
    .s_bus      (s_bus),
    .alu_op     (alu_op),
    .psw_out    (psw_out),
    .psw_update (psw_update),
    .alu_out    (alu_out),
    .alu_psw_out(alu_psw_out)
  );

  typedef struct {
    string       name;
    logic [15:0] out;
    logic [15:0] psw;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [15:0] eo, input logic [15:0] ep);
    checks++;
    if (alu_out !== eo || alu_psw_out !== ep) begin
      errors++;
      $display("FAIL %s: got alu_out=%h psw=%h, expected alu_out=%h psw=%h",
               name, alu_out, alu_psw_out, eo, ep);
    end
  endtask

  function automatic int to_signed(input int x, input int w);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  // Reference model: plain integer arithmetic over a width of 8 or 16 bits.
  function automatic logic [31:0] model(input logic [15:0] d, input logic [15:0] s,
                                        input logic [5:0] op, input logic [15:0] psw,
                                        input logic upd);
    int          code, w, mask, a, b, cin, bb, ci, sum, ssum, res, carry, t;
    bit          byte_m, keep, set_c, set_v, set_zn, c, v;
    logic [15:0] rv, out, p;
    code   = int'(op[4:0]);
    byte_m = op[5] && code < 16;
    w      = byte_m ? 8 : 16;
    mask   = (1 << w) - 1;
    a      = d & mask;
    b      = s & mask;
    cin    = int'(psw[0]);
    res    = a;
    keep   = 0; set_c = 0; set_v = 0; set_zn = 0; c = 0; v = 0;
    case (code)
      0, 1, 2, 3, 5: begin
        bb   = (code == 2 || code == 3 || code == 5) ? (~b & mask) : b;
        ci   = (code == 0) ? 0 : (code == 2 || code == 5) ? 1 : cin;
        sum  = a + bb + ci;
        res  = sum & mask;
        c    = sum > mask;
        ssum = to_signed(a, w) + to_signed(bb, w) + ci;
        v    = ssum > (1 << (w - 1)) - 1 || ssum < -(1 << (w - 1));
        set_c = 1; set_v = 1; set_zn = 1;
        keep = (code == 5);
      end
      4: begin
        carry = cin;
        res   = 0;
        for (int i = 0; i < w / 4; i++) begin
          t = ((a >> (4 * i)) & 15) + ((b >> (4 * i)) & 15) + carry;
          if (t > 9) begin t = t - 10; carry = 1; end
          else carry = 0;
          res = res | ((t & 15) << (4 * i));
        end
        c = carry; set_c = 1; set_zn = 1;
      end
      6:  begin res = a ^ b;         set_zn = 1; end
      7:  begin res = a & b;         set_zn = 1; end
      8:  begin res = a | b;         set_zn = 1; end
      9:  begin res = a & b;         set_zn = 1; keep = 1; end
      10: begin res = a & ~b & mask; set_zn = 1; end
      11: begin res = a | b;         set_zn = 1; end
      12: res = b;
      14: begin res = (a >> 1) | (a & (1 << (w - 1))); c = a & 1; set_c = 1; set_zn = 1; end
      15: begin res = (a >> 1) | (cin << (w - 1));     c = a & 1; set_c = 1; set_zn = 1; end
      16: begin res = ((a & 255) << 8) | (a >> 8); set_zn = 1; end
      17: begin res = (a & 128) ? ((a & 255) | 16'hFF00) : (a & 255); set_zn = 1; end
      default: keep = 1;
    endcase
    rv = res[15:0];
    if (keep)        out = d;
    else if (byte_m) out = {d[15:8], rv[7:0]};
    else             out = rv;
    p = psw;
    if (upd) begin
      if (set_c) p[0] = c;
      if (set_zn) begin
        p[1] = (res == 0);
        p[2] = ((res >> (w - 1)) & 1) != 0;
      end
      if (set_v) p[4] = v;
    end
    return {out, p};
  endfunction

  task automatic issue(input string name, input logic [15:0] d, input logic [15:0] s,
                       input logic [5:0] op, input logic [15:0] psw, input logic upd,
                       input logic [15:0] eo, input logic [15:0] ep);
    exp_t e;
    @(negedge Clock);
    d_bus = d; s_bus = s; alu_op = op; psw_out = psw; psw_update = upd;
    e.name = name; e.out = eo; e.psw = ep;
    sb_q.push_back(e);
  endtask

  task automatic issue_rand(input int n);
    logic [15:0] d, s, p;
    logic [5:0]  op;
    logic        u;
    logic [31:0] r;
    d = 16'($urandom); s = 16'($urandom); p = 16'($urandom);
    op = 6'($urandom_range(0, 63)); u = 1'($urandom);
    r = model(d, s, op, p, u);
    issue($sformatf("rand%0d op=%h", n, op), d, s, op, p, u, r[31:16], r[15:0]);
  endtask

  // Monitor: the DUT produces a result every edge; compare whenever one is expected.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (sb_q.size() > 0 && !Reset) begin
        e = sb_q.pop_front();
        chk(e.name, e.out, e.psw);
      end
    end
  end

  initial begin
    Reset = 1'b0; d_bus = '0; s_bus = '0; alu_op = '0; psw_out = '0; psw_update = 1'b0;
    #1 Reset = 1'b1;
    #1 chk("reset_async", 16'h0000, 16'h60E0);
    repeat (2) @(posedge Clock);
    #1 chk("reset_hold", 16'h0000, 16'h60E0);
    @(negedge Clock);
    Reset = 1'b0;

    issue("add_word",  16'h7FFF, 16'h0001, 6'd0,  16'h60E0, 1'b1, 16'h8000, 16'h60F4);
    issue("add_byte",  16'h12FF, 16'h0001, 6'h20, 16'h60E0, 1'b1, 16'h1200, 16'h60E3);
    issue("sub_eq",    16'h0005, 16'h0005, 6'd2,  16'h60E0, 1'b1, 16'h0000, 16'h60E3);
    issue("cmp_eq",    16'h0005, 16'h0005, 6'd5,  16'h60E0, 1'b1, 16'h0005, 16'h60E3);
    issue("cmp_noupd", 16'h0005, 16'h0005, 6'd5,  16'h60E0, 1'b0, 16'h0005, 16'h60E0);
    issue("sub_0_1",   16'h0000, 16'h0001, 6'd2,  16'h60E0, 1'b1, 16'hFFFF, 16'h60E4);
    issue("dadd_0999", 16'h0999, 16'h0001, 6'd4,  16'h60E0, 1'b1, 16'h1000, 16'h60E0);
    issue("dadd_9999", 16'h9999, 16'h0001, 6'd4,  16'h60E0, 1'b1, 16'h0000, 16'h60E3);
    issue("rrc",       16'h0001, 16'h0000, 6'd15, 16'h60E1, 1'b1, 16'h8000, 16'h60E5);
    issue("sra",       16'h8002, 16'h0000, 6'd14, 16'h60E0, 1'b1, 16'hC001, 16'h60E4);

    // Reset between edges during an ADD: nothing queued for that edge.
    @(negedge Clock);
    d_bus = 16'h1234; s_bus = 16'h1111; alu_op = 6'd0; psw_out = 16'h60E0; psw_update = 1'b1;
    #2 Reset = 1'b1;
    #1 chk("reset_mid", 16'h0000, 16'h60E0);
    @(posedge Clock);
    #1 chk("reset_mid_hold", 16'h0000, 16'h60E0);
    @(negedge Clock);
    Reset = 1'b0;
    sb_q.delete();

    issue("swpb", 16'h12AB, 16'h0000, 6'd16, 16'h60E0, 1'b1, 16'hAB12, 16'h60E4);

    for (int n = 0; n < 400; n++) issue_rand(n);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge Clock);
    #2;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
